add_tree_acc_pipe: RTL and testbench

//  Parametrised, pipelined signed carry-save adder tree with an output accumulator.

---
 rtl/add_tree_acc_pipe_if.sv | 25 ++
 rtl/add_tree_acc_pipe.sv | 155 +++++++++++++++
 tb/tb_add_tree_acc_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_tree_acc_pipe_if.sv
// rtl/add_tree_acc_pipe_if.sv - beat-in / result-out handshake bundle for add_tree_acc_pipe
interface add_tree_acc_pipe_if #(
  parameter int WIDTH = 53,
  parameter int N_IN  = 16,
  parameter int ACC_W = 65
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/add_tree_acc_pipe.sv
// rtl/add_tree_acc_pipe.sv - pipelined signed 4:2 CSA tree with output accumulator
// Optional saturation of ACC results is enabled by defining ADD_TREE_ACC_SAT_EN.
module add_tree_acc_pipe #(
  parameter int WIDTH = 53,
  parameter int N_IN  = 16,
  parameter int ACC_W = 65
) (
  input  logic              clk,
  input  logic              rst,
  add_tree_acc_pipe_if.slave bus
);
  localparam int L   = $clog2(N_IN) / 2;
  localparam int NPT = (N_IN - 1) / 3;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_ACC   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  // Index of the first sum/carry pair of level k in the flat pair arrays.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += N_IN >> (2 * (j + 1));
    return o;
  endfunction

  function automatic logic [2*ACC_W-1:0] csa42(
    input logic [ACC_W-1:0] a, b, c, d
  );
    logic [ACC_W-1:0] s1, c1, s2, c2;
    s1 = a ^ b ^ c;
    c1 = ((a & b) | (a & c) | (b & c)) << 1;
    s2 = s1 ^ c1 ^ d;
    c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
    return {s2, c2};
  endfunction

  logic [ACC_W-1:0] s_d [NPT];
  logic [ACC_W-1:0] c_d [NPT];
  logic [ACC_W-1:0] s_q [NPT];
  logic [ACC_W-1:0] c_q [NPT];
  logic [L-1:0]     v_q;
  logic [1:0]       m_q [L];
  logic             adv;

  // Level 0 folds 4 operands into a pair; later levels fold 4 pairs into one.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NP  = N_IN >> (2 * (k + 1));
    localparam int OFF = lvl_off(k);
    for (genvar p = 0; p < NP; p++) begin : g_pair
      if (k == 0) begin : g_leaf
        logic [ACC_W-1:0] op [4];
        for (genvar j = 0; j < 4; j++) begin : g_ext
          logic [WIDTH-1:0] raw;
          assign raw   = bus.in_data[(4*p+j)*WIDTH +: WIDTH];
          assign op[j] = {{(ACC_W-WIDTH){raw[WIDTH-1]}}, raw};
        end
        assign {s_d[OFF+p], c_d[OFF+p]} = csa42(op[0], op[1], op[2], op[3]);
      end else begin : g_node
        localparam int SRC = lvl_off(k - 1) + 4 * p;
        logic [ACC_W-1:0] x_s, x_c, y_s, y_c;
        assign {x_s, x_c} = csa42(s_q[SRC], c_q[SRC], s_q[SRC+1], c_q[SRC+1]);
        assign {y_s, y_c} = csa42(s_q[SRC+2], c_q[SRC+2], s_q[SRC+3], c_q[SRC+3]);
        assign {s_d[OFF+p], c_d[OFF+p]} = csa42(x_s, x_c, y_s, y_c);
      end
    end
  end

  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] tree_sum;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_res;

  assign bus.in_ready = !(out_valid_q && !bus.out_ready);
  assign adv          = bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPT; i++) begin
        s_q[i] <= '0;
        c_q[i] <= '0;
      end
      v_q <= '0;
      for (int i = 0; i < L; i++) m_q[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < NPT; i++) begin
        s_q[i] <= s_d[i];
        c_q[i] <= c_d[i];
      end
      v_q[0] <= bus.in_valid;
      m_q[0] <= bus.in_mode;
      for (int i = 1; i < L; i++) begin
        v_q[i] <= v_q[i-1];
        m_q[i] <= m_q[i-1];
      end
    end
  end

  assign tree_sum = s_q[NPT-1] + c_q[NPT-1];
  assign acc_sum  = acc_q + tree_sum;

`ifdef ADD_TREE_ACC_SAT_EN
  logic acc_ovf;
  logic out_sat_q;

  always_comb begin
    acc_ovf = (acc_q[ACC_W-1] == tree_sum[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    acc_res = acc_sum;
    if (acc_ovf) acc_res = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  // The tree sum alone cannot overflow given the ACC_W bound, so only ACC can flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_sat_q <= 1'b0;
    else if (adv) out_sat_q <= v_q[L-1] && (m_q[L-1] == MODE_ACC) && acc_ovf;
  end

  assign bus.out_sat = out_sat_q;
`else
  assign acc_res     = acc_sum;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
    end else if (adv) begin
      out_valid_q <= v_q[L-1];
      if (v_q[L-1]) begin
        case (m_q[L-1])
          MODE_PASS: out_data_q <= tree_sum;
          MODE_ACC: begin
            acc_q      <= acc_res;
            out_data_q <= acc_res;
          end
          MODE_LOAD: begin
            acc_q      <= tree_sum;
            out_data_q <= tree_sum;
          end
          default: begin
            acc_q      <= '0;
            out_data_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_add_tree_acc_pipe.sv
// tb/tb_add_tree_acc_pipe.sv - scoreboard bench for add_tree_acc_pipe with a behavioural model
module tb_add_tree_acc_pipe;
  localparam int WIDTH = 53;
  localparam int N_IN  = 16;
  localparam int ACC_W = 58;
  localparam int DW    = N_IN * WIDTH;

  localparam logic [1:0] M_PASS = 2'b00, M_ACC = 2'b01, M_LOAD = 2'b10, M_CLR = 2'b11;
  localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -AMAX - 1;

  logic clk;
  logic rst;

  add_tree_acc_pipe_if #(.WIDTH(WIDTH), .N_IN(N_IN), .ACC_W(ACC_W)) bus ();

  add_tree_acc_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             sat;
  } exp_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint model_acc = 0;
  bit     rnd_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic [63:0]      u;
    logic [ACC_W-1:0] t;
    u = x;
    t = u[ACC_W-1:0];
    return longint'($signed(t));
  endfunction

  // Reference: plain signed sum of operands, then the mode rule applied to a scalar acc.
  function automatic void model_beat(input logic [1:0] mode, input logic [DW-1:0] d);
    longint t;
    longint r;
    exp_t   e;
    logic [WIDTH-1:0] op;
    logic [63:0]      ru;
    t = 0;
    e.sat = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      op = d[i*WIDTH +: WIDTH];
      t += longint'($signed(op));
    end
    t = wrap(t);
    case (mode)
      M_PASS: r = t;
      M_ACC: begin
        r = model_acc + t;
`ifdef ADD_TREE_ACC_SAT_EN
        if (r > AMAX) begin r = AMAX; e.sat = 1'b1; end
        else if (r < AMIN) begin r = AMIN; e.sat = 1'b1; end
`else
        r = wrap(r);
`endif
        model_acc = r;
      end
      M_LOAD: begin
        r = t;
        model_acc = t;
      end
      default: begin
        r = 0;
        model_acc = 0;
      end
    endcase
    ru = r;
    e.data = ru[ACC_W-1:0];
    exp_q.push_back(e);
  endfunction

  function automatic logic [DW-1:0] fill(input logic [WIDTH-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < N_IN; i++) d[i*WIDTH +: WIDTH] = v;
    return d;
  endfunction

  task automatic send(input logic [1:0] mode, input logic [DW-1:0] d);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_beat(mode, d);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got no in_ready in %0d cycles expected accept", n);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t             e;
    logic             stalled;
    logic [ACC_W-1:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        if (stalled) check("hold_data", 64'(bus.out_data), 64'(held));
        if (bus.out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got 0x%0h expected no result", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e.data));
            check("out_sat", 64'(bus.out_sat), 64'(e.sat));
          end
        end else begin
          check("in_ready_stall", 64'(bus.in_ready), 64'd0);
          stalled = 1'b1;
          held    = bus.out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : driver
    logic [DW-1:0]    d;
    logic [63:0]      r;
    logic [WIDTH-1:0] pmax;
    logic [WIDTH-1:0] nmin;
    int               lat;
    int               waited;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = M_PASS;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // All ones through PASS, with accept-to-valid latency.
    send(M_PASS, fill(WIDTH'(1)));
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    @(posedge clk);
    #1;

    // Extreme alternating operands exercise sign extension.
    pmax = {1'b0, {(WIDTH-1){1'b1}}};
    nmin = {1'b1, {(WIDTH-1){1'b0}}};
    for (int i = 0; i < N_IN; i++) d[i*WIDTH +: WIDTH] = (i % 2 == 0) ? pmax : nmin;
    send(M_PASS, d);

    // LOAD then chained ACC beats back-to-back.
    send(M_LOAD, fill(WIDTH'(2)));
    send(M_ACC, fill(WIDTH'(3)));
    send(M_ACC, fill('1));
    repeat (5) @(posedge clk);
    #1;

    // Downstream stall with three beats in flight.
    bus.out_ready = 1'b0;
    send(M_LOAD, fill(WIDTH'(2)));
    send(M_ACC, fill(WIDTH'(3)));
    send(M_ACC, fill('1));
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of an ACC stream.
    send(M_ACC, fill(WIDTH'(1)));
    send(M_ACC, fill(WIDTH'(1)));
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    exp_q.delete();
    model_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(M_ACC, fill('0));
    send(M_LOAD, fill(WIDTH'(1)));
    repeat (5) @(posedge clk);
    #1;

    // Repeated large ACC beats run past the accumulator range.
    send(M_CLR, fill(WIDTH'(7)));
    for (int i = 0; i < 4; i++) send(M_ACC, fill(pmax));
    repeat (5) @(posedge clk);
    #1;

    // Random beats, modes, gaps and downstream backpressure.
    fork
      begin
        for (int b = 0; b < 300; b++) begin
          for (int i = 0; i < N_IN; i++) begin
            r = {$urandom(), $urandom()};
            d[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
          end
          send(2'($urandom_range(0, 3)), d);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
